exu_dispatch: RTL and testbench

//   Sequencer for the execute stage: accepts one decoded instruction from IDU, routes it to the

---
 rtl/exu_dispatch.sv | 137 +++++++++++++
 tb/tb_exu_dispatch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/exu_dispatch.sv
// Execute-stage sequencer: routes one instruction at a time to fu or lsu, collects the
// result for WBU, and keeps a hang watchdog plus performance counters.
module exu_dispatch #(
    parameter logic [7:0] LOAD_TYPE  = 8'h03,
    parameter logic [7:0] STORE_TYPE = 8'h23,
    parameter int         TMO_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        idu_valid_i,
    output logic        exu_ready_o,
    input  logic [7:0]  inst_type_i,
    output logic        fu_valid_o,
    input  logic        fu_ready_i,
    input  logic        fu_done_valid_i,
    output logic        fu_done_ready_o,
    input  logic [31:0] fu_result_i,
    output logic        lsu_valid_o,
    input  logic        lsu_ready_i,
    input  logic        lsu_done_valid_i,
    output logic        lsu_done_ready_o,
    input  logic [31:0] lsu_result_i,
    output logic        wbu_valid_o,
    input  logic        wbu_ready_i,
    output logic [31:0] wbu_result_o,
    output logic        wbu_from_lsu_o,
    output logic        timeout_o,
    output logic [31:0] nr_fu_o,
    output logic [31:0] nr_lsu_o,
    output logic [31:0] nr_busy_o
);

    // state | meaning
    // IDLE  | ready for a new instruction from IDU
    // ISSUE | request held toward the selected unit
    // WAIT  | waiting for the selected unit's result
    // WB    | result presented to WBU
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_WB    = 4'b1000
    } state_t;

    localparam int             TW       = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LOAD = TW'(TMO_CYCLES);
    localparam logic [TW-1:0]  TMO_ONE  = TW'(1);

    state_t        state, state_nxt;
    logic          sel;
    logic          accept, done_hs, wb_hs;
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        exu_ready_o      = 1'b0;
        fu_valid_o       = 1'b0;
        lsu_valid_o      = 1'b0;
        fu_done_ready_o  = 1'b0;
        lsu_done_ready_o = 1'b0;
        wbu_valid_o      = 1'b0;
        accept           = 1'b0;
        done_hs          = 1'b0;
        wb_hs            = 1'b0;
        unique case (state)
            S_IDLE: begin
                exu_ready_o = 1'b1;
                if (idu_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fu_valid_o  = !sel;
                lsu_valid_o = sel;
                if (sel ? lsu_ready_i : fu_ready_i) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                fu_done_ready_o  = !sel;
                lsu_done_ready_o = sel;
                if (sel ? lsu_done_valid_i : fu_done_valid_i) begin
                    done_hs   = 1'b1;
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                wbu_valid_o = 1'b1;
                if (wbu_ready_i) begin
                    wb_hs     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel            <= 1'b0;
            wbu_result_o   <= 32'd0;
            wbu_from_lsu_o <= 1'b0;
            nr_fu_o        <= 32'd0;
            nr_lsu_o       <= 32'd0;
            nr_busy_o      <= 32'd0;
        end else begin
            if (accept) sel <= (inst_type_i == LOAD_TYPE) || (inst_type_i == STORE_TYPE);
            if (done_hs) begin
                wbu_result_o   <= sel ? lsu_result_i : fu_result_i;
                wbu_from_lsu_o <= sel;
            end
            if (wb_hs) begin
                if (wbu_from_lsu_o) nr_lsu_o <= nr_lsu_o + 32'd1;
                else                nr_fu_o  <= nr_fu_o + 32'd1;
            end
            if (state != S_IDLE) nr_busy_o <= nr_busy_o + 32'd1;
        end
    end

    // Watchdog counts down from TMO_CYCLES; reaching zero flags the hang but never aborts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt   <= '0;
            timeout_o <= 1'b0;
        end else if (accept) begin
            tmo_cnt <= TMO_LOAD;
        end else if ((state == S_ISSUE || state == S_WAIT) && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TMO_ONE;
            if (tmo_cnt == TMO_ONE) timeout_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_exu_dispatch.sv
// Bench for exu_dispatch: per-instruction schedules (table, hand-written and random) are
// driven cycle by cycle and every output is compared against a schedule-derived model.
module tb_exu_dispatch;

    localparam logic [7:0] LOAD_T  = 8'h03;
    localparam logic [7:0] STORE_T = 8'h23;
    localparam int         TMO     = 8;

    logic        clock, reset;
    logic        idu_valid_i, exu_ready_o;
    logic [7:0]  inst_type_i;
    logic        fu_valid_o, fu_ready_i, fu_done_valid_i, fu_done_ready_o;
    logic [31:0] fu_result_i;
    logic        lsu_valid_o, lsu_ready_i, lsu_done_valid_i, lsu_done_ready_o;
    logic [31:0] lsu_result_i;
    logic        wbu_valid_o, wbu_ready_i, wbu_from_lsu_o, timeout_o;
    logic [31:0] wbu_result_o, nr_fu_o, nr_lsu_o, nr_busy_o;

    exu_dispatch #(.LOAD_TYPE(LOAD_T), .STORE_TYPE(STORE_T), .TMO_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .idu_valid_i(idu_valid_i), .exu_ready_o(exu_ready_o), .inst_type_i(inst_type_i),
        .fu_valid_o(fu_valid_o), .fu_ready_i(fu_ready_i), .fu_done_valid_i(fu_done_valid_i),
        .fu_done_ready_o(fu_done_ready_o), .fu_result_i(fu_result_i),
        .lsu_valid_o(lsu_valid_o), .lsu_ready_i(lsu_ready_i), .lsu_done_valid_i(lsu_done_valid_i),
        .lsu_done_ready_o(lsu_done_ready_o), .lsu_result_i(lsu_result_i),
        .wbu_valid_o(wbu_valid_o), .wbu_ready_i(wbu_ready_i), .wbu_result_o(wbu_result_o),
        .wbu_from_lsu_o(wbu_from_lsu_o), .timeout_o(timeout_o),
        .nr_fu_o(nr_fu_o), .nr_lsu_o(nr_lsu_o), .nr_busy_o(nr_busy_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  typ;
        int          gap, k, m, w;
        logic [31:0] res;
        logic        both;
        logic [31:0] oth;
        logic        exp_lsu;
    } vec_t;

    vec_t        tbl [6];
    int          n_vec, n_bad;
    logic [31:0] m_last, m_fu, m_lsu, m_busy;
    logic        m_from, m_tmo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input logic [7:0] e_hs, input logic [31:0] e_res);
        chk("handshakes", {24'd0, exu_ready_o, fu_valid_o, fu_done_ready_o, lsu_valid_o,
                           lsu_done_ready_o, wbu_valid_o, wbu_from_lsu_o, timeout_o}, {24'd0, e_hs});
        chk("wbu_result", wbu_result_o, e_res);
        chk("nr_fu", nr_fu_o, m_fu);
        chk("nr_lsu", nr_lsu_o, m_lsu);
        chk("nr_busy", nr_busy_o, m_busy);
    endtask

    task automatic model_reset();
        m_last = 32'd0; m_fu = 32'd0; m_lsu = 32'd0; m_busy = 32'd0;
        m_from = 1'b0;  m_tmo = 1'b0;
    endtask

    // One instruction: accept at offset 0, selected unit ready at 1+k, result at 2+k+m,
    // WBU ready at 3+k+m+w. Called at posedge+1 with the DUT idle.
    task automatic run_instr(input logic [7:0] typ, input int gap, input int k, input int m,
                             input int w, input logic [31:0] res, input logic both,
                             input logic [31:0] oth, input logic sel);
        int          n_act;
        logic        s_rdy, s_done, o_rdy, o_done, idle, iss, wt, wb, e_tmo;
        logic [31:0] s_res, o_res;
        n_act = 2 + k + m;
        for (int c = -gap; c <= 3 + k + m + w; c++) begin
            idu_valid_i = (c < 0) ? 1'b0 : (c == 0) ? 1'b1 : 1'($urandom % 2);
            inst_type_i = (c == 0) ? typ : 8'($urandom);
            s_rdy  = (c == 1 + k);
            s_done = (c == 2 + k + m);
            o_rdy  = 1'($urandom % 2);
            o_done = both ? s_done : 1'($urandom % 2);
            s_res  = s_done ? res : $urandom;
            o_res  = (both && s_done) ? oth : $urandom;
            fu_ready_i       = sel ? o_rdy  : s_rdy;
            lsu_ready_i      = sel ? s_rdy  : o_rdy;
            fu_done_valid_i  = sel ? o_done : s_done;
            lsu_done_valid_i = sel ? s_done : o_done;
            fu_result_i      = sel ? o_res  : s_res;
            lsu_result_i     = sel ? s_res  : o_res;
            wbu_ready_i = (c == 3 + k + m + w) ? 1'b1 : (c < 3 + k + m) ? 1'($urandom % 2) : 1'b0;
            @(negedge clock);
            idle  = (c <= 0);
            iss   = (c >= 1) && (c <= 1 + k);
            wt    = (c >= 2 + k) && (c <= 2 + k + m);
            wb    = (c >= 3 + k + m);
            e_tmo = m_tmo || (n_act >= TMO && c >= 1 + TMO);
            check_all({idle, iss & !sel, wt & !sel, iss & sel, wt & sel, wb,
                       wb ? sel : m_from, e_tmo}, wb ? res : m_last);
            if (c >= 1) m_busy = m_busy + 32'd1;
            @(posedge clock);
            #1;
        end
        m_last = res;
        m_from = sel;
        m_tmo  = m_tmo || (n_act >= TMO);
        if (sel) m_lsu = m_lsu + 32'd1;
        else     m_fu  = m_fu + 32'd1;
    endtask

    task automatic run_random(input int count, input int kmax);
        logic [7:0] typ;
        int         r;
        for (int i = 0; i < count; i++) begin
            r = $urandom % 3;
            if (r == 0)      typ = LOAD_T;
            else if (r == 1) typ = STORE_T;
            else begin
                typ = 8'($urandom);
                if (typ == LOAD_T || typ == STORE_T) typ = 8'h33;
            end
            run_instr(typ, $urandom % 3, $urandom % (kmax + 1), $urandom % (kmax + 1),
                      $urandom % 4, $urandom, 1'($urandom % 2), $urandom,
                      (typ == LOAD_T) || (typ == STORE_T));
        end
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        model_reset();
        tbl[0] = '{8'h33,   0, 0, 0, 0,  32'h0000_1234, 1'b0, 32'h0,      1'b0};
        tbl[1] = '{LOAD_T,  0, 5, 0, 0,  32'hDEAD_BEEF, 1'b0, 32'h0,      1'b1};
        tbl[2] = '{8'h33,   1, 1, 1, 0,  32'hA5A5_0001, 1'b1, 32'h0000_FFFF, 1'b0};
        tbl[3] = '{STORE_T, 0, 0, 2, 10, 32'hCAFE_F00D, 1'b0, 32'h0,      1'b1};
        tbl[4] = '{8'h13,   2, 2, 3, 1,  32'h0000_0000, 1'b0, 32'h0,      1'b0};
        tbl[5] = '{LOAD_T,  0, 0, 0, 0,  32'h0000_0077, 1'b1, 32'h0000_1111, 1'b1};

        reset = 1'b0;
        idu_valid_i = 1'b0; inst_type_i = 8'h0;
        fu_ready_i = 1'b0; fu_done_valid_i = 1'b0; fu_result_i = 32'h0;
        lsu_ready_i = 1'b0; lsu_done_valid_i = 1'b0; lsu_result_i = 32'h0;
        wbu_ready_i = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_all(8'b1000_0000, 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;

        for (int i = 0; i < 6; i++)
            run_instr(tbl[i].typ, tbl[i].gap, tbl[i].k, tbl[i].m, tbl[i].w,
                      tbl[i].res, tbl[i].both, tbl[i].oth, tbl[i].exp_lsu);

        run_random(30, 2);

        // fu stalls well past the watchdog limit; flag must rise and stick.
        run_instr(8'h33, 0, 20, 0, 0, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0);
        run_random(3, 2);

        // Reset asserted while waiting for the fu result.
        idu_valid_i = 1'b1; inst_type_i = 8'h33; fu_ready_i = 1'b1;
        fu_done_valid_i = 1'b0; lsu_done_valid_i = 1'b0; wbu_ready_i = 1'b0;
        @(posedge clock); #1;
        idu_valid_i = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("wait_before_reset", {31'd0, fu_done_ready_o}, 32'd1);
        #2 reset = 1'b0;
        model_reset();
        @(negedge clock);
        check_all(8'b1000_0000, 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;

        run_random(30, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
